// File: rtl/lfsr_shifter.sv
// Prescaled LFSR / rotator with synchronised injection inputs and parallel load.
// Optional lock-up escape reseed is enabled by defining LFSR_SHIFTER_ESCAPE_EN.
module lfsr_shifter #(
  parameter int unsigned    WIDTH = 32,
  parameter int unsigned    OUT_W = 8,
  parameter int unsigned    NIN   = 8,
  parameter int unsigned    DIV_W = 21,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(171)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] rate,
  input  logic [WIDTH-1:0] taps,
  input  logic [NIN-1:0]   inj,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [OUT_W-1:0] data,
  output logic             serout,
  output logic             tick_o,
  output logic             lockup_o
);

  logic [WIDTH-1:0] shifter_q, shifter_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [NIN-1:0]   inj_meta_q, inj_s_q;
  logic             tick_q, tick_d;
  logic             tick;
  logic             fb;
  logic             escape;
  logic             lockup_d;

  assign tick = (cnt_q >= rate);

  always_comb begin
    fb = 1'b0;
    case (mode)
      2'b01:   fb = (^(shifter_q & taps)) ^ (^inj_s_q);
      2'b10:   fb = shifter_q[WIDTH-1];
      2'b11:   fb = ^inj_s_q;
      default: fb = 1'b0;
    endcase
  end

`ifdef LFSR_SHIFTER_ESCAPE_EN
  assign escape = (mode == 2'b01) && (shifter_q == '0) && !fb;
`else
  assign escape = 1'b0;
`endif

  // Load wins over a tick and restarts the prescaler.
  always_comb begin
    shifter_d = shifter_q;
    cnt_d     = cnt_q + DIV_W'(1);
    tick_d    = 1'b0;
    lockup_d  = 1'b0;
    if (load) begin
      shifter_d = load_data;
      cnt_d     = '0;
    end else if (tick) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      if (escape) begin
        shifter_d = SEED;
        lockup_d  = 1'b1;
      end else if (mode != 2'b00) begin
        shifter_d = {shifter_q[WIDTH-2:0], fb};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shifter_q  <= SEED;
      cnt_q      <= '0;
      inj_meta_q <= '0;
      inj_s_q    <= '0;
      tick_q     <= 1'b0;
    end else begin
      shifter_q  <= shifter_d;
      cnt_q      <= cnt_d;
      inj_meta_q <= inj;
      inj_s_q    <= inj_meta_q;
      tick_q     <= tick_d;
    end
  end

`ifdef LFSR_SHIFTER_ESCAPE_EN
  logic lockup_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lockup_q <= 1'b0;
    end else begin
      lockup_q <= lockup_d;
    end
  end

  assign lockup_o = lockup_q;
`else
  logic unused_lockup;
  assign unused_lockup = lockup_d;
  assign lockup_o      = 1'b0;
`endif

  assign data   = shifter_q[OUT_W-1:0];
  assign serout = shifter_q[WIDTH-1];
  assign tick_o = tick_q;

endmodule

// File: doc/lfsr_shifter.md
LFSR_SHIFTER -- requirements
Module: lfsr_shifter

Interface
- REQ-001 Parameter WIDTH, default 32: shift register length, legal range 8..64.
- REQ-002 Parameter OUT_W, default 8: parallel output width, 1..WIDTH.
- REQ-003 Parameter NIN, default 8: injection input count, 1..16.
- REQ-004 Parameter DIV_W, default 21: prescaler counter width.
- REQ-005 Parameter SEED, default 171: reset and reseed value, WIDTH bits, nonzero.
- REQ-006 clk  in  1  system clock; all state changes on its rising edge.
- REQ-007 rst_n  in  1  reset; one clock, asynchronous, active-low.
- REQ-008 mode  in  2  00 hold, 01 LFSR, 10 rotate, 11 inject-only.
- REQ-009 rate  in  DIV_W  prescaler terminal count; a tick occurs every rate+1 cycles.
- REQ-010 taps  in  WIDTH  feedback tap mask (bit i set = shifter[i] tapped).
- REQ-011 inj  in  NIN  asynchronous injection inputs (pins idle high under pull-ups).
- REQ-012 load  in  1  synchronous parallel load strobe.
- REQ-013 load_data  in  WIDTH  value loaded when load=1.
- REQ-014 data  out  OUT_W  shifter[OUT_W-1:0].
- REQ-015 serout  out  1  shifter[WIDTH-1].
- REQ-016 tick_o  out  1  one-cycle pulse on each prescaler tick.
- REQ-017 lockup_o  out  1  one-cycle pulse on each escape reseed.

Function
- REQ-018 Each inj bit passes through a 2-flop synchroniser; inj_s is the second stage.
- REQ-019 Prescaler cnt: if cnt >= rate then tick=1 and cnt<=0, else cnt<=cnt+1; rate=0 ticks every cycle; lowering rate below cnt ticks on the next cycle.
- REQ-020 Feedback fb: mode 01 = ^(shifter & taps) ^ ^inj_s; mode 10 = shifter[WIDTH-1]; mode 11 = ^inj_s.
- REQ-021 On a tick with mode != 00: shifter <= {shifter[WIDTH-2:0], fb}.
- REQ-022 Mode 00: shifter holds; prescaler keeps counting; tick_o still pulses.
- REQ-023 load=1 takes priority over tick: shifter <= load_data and cnt <= 0 in the same edge; no shift that cycle; tick_o = 0 that cycle.
- REQ-024 data and serout are driven directly from the shifter register: zero latency after the updating edge.
- REQ-025 tick_o is registered and asserts in the same cycle the shift it accompanies becomes visible.
- REQ-026 Latency from an inj edge to its effect on fb: 2 clk cycles, then the next tick.
- REQ-027 mode and taps are sampled only on tick edges; changing them between ticks has no effect until the next tick.

Reset
- REQ-028 With rst_n=0: shifter=SEED, cnt=0, sync flops=0, tick_o=0, lockup_o=0, data=SEED[OUT_W-1:0], serout=SEED[WIDTH-1]; this applies immediately, without waiting for clk.
- REQ-029 After rst_n deasserts, the first tick occurs rate+1 edges later.

Configuration
- REQ-030 Macro LFSR_SHIFTER_ESCAPE_EN defined: on a tick in mode 01 with shifter==0 and fb==0, shifter <= SEED and lockup_o pulses for 1 cycle; load still has priority.
- REQ-031 Macro LFSR_SHIFTER_ESCAPE_EN undefined: the all-zero state persists until inj or load changes it; lockup_o is tied to 0.

Verification
- REQ-032 Reset, mode=01, rate=0, taps=0xA3000000, inj=all 0 -> data sequence 0xAB, 0x56, 0xAC; shifter 0x000000AB -> 0x00000156 -> 0x000002AC.
- REQ-033 load_data=0x80000001 with load=1, then mode=10, rate=0 -> shifter=0x00000003 next edge, serout=0.
- REQ-034 rate=3, mode=01 -> tick_o high every 4th cycle; shifter changes only on those edges; rate set to 1 while cnt=3 -> tick on the next edge.
- REQ-035 load_data=0, mode=01, inj=all 0, rate=0 -> with ESCAPE_EN: shifter=SEED and lockup_o=1 on the next edge; without ESCAPE_EN: shifter stays 0 and lockup_o=0.
- REQ-036 After load of 0, mode=11, rate=0, inj=0x01 -> shifter LSB is 1 from the third edge onward; 4 edges later shifter=0x00000003 (two synchroniser edges, then ones shifting in).
- REQ-037 rst_n pulsed low mid-count with cnt=2 and rate=5 -> data=0xAB asynchronously; tick_o next asserts 6 edges after release.
